// File: rtl/square_sequencer.sv
// ============================================================================
// Module   : square_sequencer
// Purpose  : Note sequencer and amplitude controller for the square-wave
//            voice. Queues note commands, generates the sample step strobe,
//            counts note length in frames and scales the generator output
//            by a decaying 4-bit volume envelope.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   cmd_valid_in    command present
//   cmd_ready_out   command can be accepted (queue not full)
//   cmd_tone_in     [9:0] tone index
//   cmd_vol_in      [3:0] initial volume
//   cmd_len_in      [7:0] note length in frames, 0 = sustain
//   cmd_decay_in    enable envelope decay
//   step_out        one-cycle sample strobe to the generator
//   tone_out        [9:0] tone to the generator
//   gen_rst_out     generator phase reset
//   amp_in          [7:0] signed generator sample
//   amp_out         [7:0] signed enveloped sample (registered)
//   busy_out        high whenever the sequencer is not idle
// Configuration
//   SQUARE_SEQ_QUEUE_EN defined   : QUEUE_DEPTH-entry circular FIFO
//   SQUARE_SEQ_QUEUE_EN undefined : single holding register
// ============================================================================
`default_nettype none

module square_sequencer #(
  parameter int SAMPLE_DIV  = 8333,
  parameter int FRAME_DIV   = 200,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [9:0]        cmd_tone_in,
  input  logic [3:0]        cmd_vol_in,
  input  logic [7:0]        cmd_len_in,
  input  logic              cmd_decay_in,
  output logic              step_out,
  output logic [9:0]        tone_out,
  output logic              gen_rst_out,
  input  logic signed [7:0] amp_in,
  output logic signed [7:0] amp_out,
  output logic              busy_out
);

  localparam int c_DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int c_FRM_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int c_CMD_W = 23;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_PLAY  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [c_FRM_W-1:0]   r_frame_cnt;
  logic                 w_step;
  logic                 w_frame_end;
  logic                 w_frame_tick;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [c_CMD_W-1:0]   w_cmd_in;
  logic [c_CMD_W-1:0]   w_head;
  logic [9:0]           r_tone;
  logic [3:0]           r_vol;
  logic [7:0]           r_len_cnt;
  logic                 r_decay;
  logic [1:0]           r_decay_cnt;
  logic signed [7:0]    r_amp;
  logic signed [12:0]   w_amp_ext;
  logic signed [12:0]   w_vol_ext;
  logic signed [12:0]   w_prod;
  logic                 w_unused_prod_bits;

  // Command packing: {tone, vol, len, decay}
  assign w_cmd_in = {cmd_tone_in, cmd_vol_in, cmd_len_in, cmd_decay_in};
  assign w_push   = cmd_valid_in && cmd_ready_out;
  assign w_pop    = (r_state == S_START);
  assign cmd_ready_out = !w_full;

`ifdef SQUARE_SEQ_QUEUE_EN
  localparam int c_PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [c_CMD_W-1:0] r_fifo [QUEUE_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  assign w_full  = (r_count == (c_PTR_W+1)'(QUEUE_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_cmd_in;
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
`else
  localparam int c_unused_depth = QUEUE_DEPTH;

  logic               r_held;
  logic [c_CMD_W-1:0] r_hold;

  assign w_full  = r_held;
  assign w_empty = !r_held;
  assign w_head  = r_hold;

  always_ff @(posedge clk_in) begin
    if (w_push) r_hold <= w_cmd_in;
  end

  // Push and pop never coincide here: ready is low whenever a pop is possible.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_held <= 1'b0;
    else if (w_push) r_held <= 1'b1;
    else if (w_pop)  r_held <= 1'b0;
  end
`endif

  // Free-running sample divider
  assign w_step = (r_div_cnt == c_DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_div_cnt <= '0;
    else if (w_step) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  assign w_frame_end  = (r_frame_cnt == c_FRM_W'(FRAME_DIV - 1));
  assign w_frame_tick = (r_state == S_PLAY) && w_step && w_frame_end;

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state. A sustained note (len 0) only yields on a frame tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (w_frame_tick) begin
          if (r_len_cnt != 8'd0) begin
            if (r_len_cnt == 8'd1) w_state_nxt = w_empty ? S_IDLE : S_START;
          end else if (!w_empty) begin
            w_state_nxt = S_START;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Note parameters, frame counter and envelope
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tone      <= '0;
      r_vol       <= '0;
      r_len_cnt   <= '0;
      r_decay     <= 1'b0;
      r_decay_cnt <= '0;
      r_frame_cnt <= '0;
    end else if (r_state == S_START) begin
      {r_tone, r_vol, r_len_cnt, r_decay} <= w_head;
      r_frame_cnt <= '0;
      r_decay_cnt <= '0;
    end else if ((r_state == S_PLAY) && w_step) begin
      if (w_frame_end) begin
        r_frame_cnt <= '0;
        if (r_len_cnt != 8'd0) r_len_cnt <= r_len_cnt - 8'd1;
        if (r_decay) begin
          r_decay_cnt <= r_decay_cnt + 2'd1;
          // Volume steps down every fourth frame and holds at zero.
          if ((r_decay_cnt == 2'd3) && (r_vol != 4'd0)) r_vol <= r_vol - 4'd1;
        end
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Envelope: amp * vol / 16. The product fits in 12 bits, so [11:4] is exact.
  assign w_amp_ext = {{5{amp_in[7]}}, amp_in};
  assign w_vol_ext = {9'd0, r_vol};
  assign w_prod    = w_amp_ext * w_vol_ext;
  assign w_unused_prod_bits = ^{w_prod[12], w_prod[3:0]};

  // Keyed on the next state so the output is already zero in the first IDLE cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                      r_amp <= '0;
    else if (w_state_nxt == S_IDLE)  r_amp <= '0;
    else                             r_amp <= w_prod[11:4];
  end

  assign step_out    = w_step;
  assign tone_out    = r_tone;
  assign gen_rst_out = (r_state != S_PLAY);
  assign amp_out     = r_amp;
  assign busy_out    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_square_sequencer.sv
// ============================================================================
// Module   : tb_square_sequencer
// Purpose  : Self-checking bench for square_sequencer with a queue-based
//            behavioural reference model of the note sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_sequencer;

  localparam int SD = 4;
  localparam int FD = 3;
`ifdef SQUARE_SEQ_QUEUE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              cmd_valid_in;
  logic              cmd_ready_out;
  logic [9:0]        cmd_tone_in;
  logic [3:0]        cmd_vol_in;
  logic [7:0]        cmd_len_in;
  logic              cmd_decay_in;
  logic              step_out;
  logic [9:0]        tone_out;
  logic              gen_rst_out;
  logic signed [7:0] amp_in;
  logic signed [7:0] amp_out;
  logic              busy_out;

  always #5 clk_in = ~clk_in;

  square_sequencer #(
    .SAMPLE_DIV (SD),
    .FRAME_DIV  (FD),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cmd_valid_in (cmd_valid_in),
    .cmd_ready_out(cmd_ready_out),
    .cmd_tone_in  (cmd_tone_in),
    .cmd_vol_in   (cmd_vol_in),
    .cmd_len_in   (cmd_len_in),
    .cmd_decay_in (cmd_decay_in),
    .step_out     (step_out),
    .tone_out     (tone_out),
    .gen_rst_out  (gen_rst_out),
    .amp_in       (amp_in),
    .amp_out      (amp_out),
    .busy_out     (busy_out)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending notes in a queue, playing note as plain integers.
  typedef struct {int tone; int vol; int len; int decay;} cmd_t;
  cmd_t mq[$];
  int m_div, m_frame, m_mode, m_tone, m_vol, m_len, m_decay, m_dcnt, m_amp;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    mq.delete();
    m_div = 0; m_frame = 0; m_mode = 0; m_tone = 0; m_vol = 0;
    m_len = 0; m_decay = 0; m_dcnt = 0; m_amp = 0;
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_step();
    bit   step;
    bit   push;
    bit   pending;
    int   nmode;
    int   cur_vol;
    cmd_t c;
    step    = (m_div == SD - 1);
    push    = cmd_valid_in && (mq.size() < DEPTH);
    pending = (mq.size() != 0);
    nmode   = m_mode;
    cur_vol = m_vol;
    if (m_mode == 0) begin
      if (pending) nmode = 1;
    end else if (m_mode == 1) begin
      c = mq.pop_front();
      m_tone = c.tone; m_vol = c.vol; m_len = c.len; m_decay = c.decay;
      m_frame = 0; m_dcnt = 0;
      nmode = 2;
    end else if (step) begin
      if (m_frame == FD - 1) begin
        m_frame = 0;
        if (m_len != 0) begin
          m_len--;
          if (m_len == 0) nmode = pending ? 1 : 0;
        end else if (pending) begin
          nmode = 1;
        end
        if (m_decay != 0) begin
          m_dcnt = (m_dcnt + 1) % 4;
          if (m_dcnt == 0 && m_vol > 0) m_vol--;
        end
      end else begin
        m_frame++;
      end
    end
    m_amp = (nmode == 0) ? 0 : ((int'(amp_in) * cur_vol) >>> 4);
    if (push) begin
      c.tone = int'(cmd_tone_in); c.vol = int'(cmd_vol_in);
      c.len = int'(cmd_len_in); c.decay = int'(cmd_decay_in);
      mq.push_back(c);
    end
    m_div  = (m_div + 1) % SD;
    m_mode = nmode;
  endtask

  task automatic check_model();
    chk("step_out", step_out, (m_div == SD - 1));
    chk("cmd_ready_out", cmd_ready_out, (mq.size() < DEPTH));
    chk("gen_rst_out", gen_rst_out, (m_mode != 2));
    chk("busy_out", busy_out, (m_mode != 0));
    chk("tone_out", tone_out, m_tone);
    chk("amp_out", amp_out, m_amp);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check_model();
  endtask

  task automatic set_cmd(input int tone, input int vol, input int len, input int decay);
    cmd_tone_in  = 10'(tone);
    cmd_vol_in   = 4'(vol);
    cmd_len_in   = 8'(len);
    cmd_decay_in = 1'(decay);
  endtask

  task automatic push(input int tone, input int vol, input int len, input int decay);
    bit done;
    done = 1'b0;
    set_cmd(tone, vol, len, decay);
    cmd_valid_in = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (cmd_ready_out) done = 1'b1;
      cycle();
    end
    cmd_valid_in = 1'b0;
    chk("push_accepted", done, 1'b1);
  endtask

  task automatic try_push(input int tone, output bit accepted);
    set_cmd(tone, 5, 1, 0);
    cmd_valid_in = 1'b1;
    accepted = cmd_ready_out;
    cycle();
    cmd_valid_in = 1'b0;
  endtask

  task automatic wait_play(input int limit);
    for (int i = 0; i < limit && gen_rst_out; i++) cycle();
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy_out; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    rst_in = 1'b1;
    #1;
    model_reset();
    check_model();
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check_model();
    end
    rst_in = 1'b0;
  endtask

  initial begin
    bit acc;
    int n_acc;
    bit prev;
    bit saw;
    int got[$];

    rst_in = 1'b1;
    cmd_valid_in = 1'b0;
    set_cmd(0, 0, 0, 0);
    amp_in = '0;
    model_reset();
    @(negedge clk_in);

    // Reset values
    do_reset(3);
    chk("rst_ready", cmd_ready_out, 1'b1);
    chk("rst_step", step_out, 1'b0);
    chk("rst_tone", tone_out, 0);
    chk("rst_genrst", gen_rst_out, 1'b1);
    chk("rst_amp", amp_out, 0);
    chk("rst_busy", busy_out, 1'b0);

    // Free-running step strobe
    for (int i = 0; i < 12; i++) begin
      amp_in = 8'($urandom);
      cycle();
    end

    // Single note
    amp_in = 8'sd127;
    push(100, 15, 2, 0);
    wait_play(20);
    chk("note_genrst_low", gen_rst_out, 1'b0);
    chk("note_tone", tone_out, 100);
    cycle();
    chk("note_amp", amp_out, 119);
    wait_idle(60);
    chk("note_idle", busy_out, 1'b0);
    chk("note_idle_amp", amp_out, 0);

    // Decay envelope on a sustained note
    amp_in = -8'sd128;
    push(50, 2, 0, 1);
    wait_play(20);
    cycle();
    chk("decay_first", amp_out, -16);
    for (int i = 0; i < 80 && amp_out == -8'sd16; i++) cycle();
    chk("decay_second", amp_out, -8);
    for (int i = 0; i < 80 && amp_out == -8'sd8; i++) cycle();
    chk("decay_zero", amp_out, 0);
    for (int i = 0; i < 30; i++) cycle();
    chk("decay_busy", busy_out, 1'b1);

    // Sustain replacement on a frame boundary
    cycle();
    push(200, 9, 1, 0);
    chk("sust_hold", tone_out, 50);
    prev = gen_rst_out;
    for (int i = 0; i < 40 && tone_out != 10'd200; i++) begin
      prev = gen_rst_out;
      cycle();
    end
    chk("sust_tone", tone_out, 200);
    chk("sust_pulse", prev, 1'b1);
    chk("sust_play", gen_rst_out, 1'b0);
    wait_idle(60);

    // Queue full while busy, then in-order playback
    push(300, 5, 3, 0);
    wait_play(20);
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      try_push(301 + i, acc);
      if (acc) n_acc++;
    end
    chk("qfull_accepts", n_acc, DEPTH);
    chk("qfull_ready", cmd_ready_out, 1'b0);
    for (int i = 0; i < 400 && busy_out; i++) begin
      prev = gen_rst_out;
      cycle();
      if (prev && !gen_rst_out) got.push_back(int'(tone_out));
    end
    chk("qfull_count", got.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      chk("qfull_order", (got.size() > i) ? got[i] : -1, 301 + i);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      amp_in       = 8'($urandom);
      cmd_valid_in = ($urandom_range(0, 2) == 0);
      set_cmd($urandom_range(0, 1023), $urandom_range(0, 15),
              $urandom_range(0, 2), $urandom_range(0, 1));
      cycle();
    end
    cmd_valid_in = 1'b0;

    // Reset mid-note with commands queued
    do_reset(1);
    amp_in = 8'sd100;
    push(500, 7, 3, 0);
    wait_play(20);
    try_push(501, acc);
    try_push(502, acc);
    cycle();
    rst_in = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", busy_out, 1'b0);
    chk("midrst_amp", amp_out, 0);
    chk("midrst_ready", cmd_ready_out, 1'b1);
    chk("midrst_genrst", gen_rst_out, 1'b1);
    chk("midrst_tone", tone_out, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check_model();
    end
    rst_in = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      amp_in = 8'($urandom);
      cycle();
      if (busy_out) saw = 1'b1;
    end
    chk("midrst_no_replay", saw, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
